// File: rtl/led_button_pkg.sv
// Shared types and helpers for the multi-channel button/LED block.
package led_button_pkg;

    // LED mode per channel; 2'd3 is never written and recovers to OFF.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2
    } mode_t;

    // Press classifier state per channel.
    typedef enum logic [1:0] {
        P_IDLE      = 2'd0,
        P_PRESSED   = 2'd1,
        P_LONG_HELD = 2'd2
    } press_state_t;

    // Converts a duration in milliseconds to clk cycles.
    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/led_button_array_debounce.sv
// Single-channel button conditioner: 2-FF synchroniser, polarity
// normalisation (pressed = 1) and a stable-time debouncer.
module btn_debounce
    import led_button_pkg::*;
#(
    parameter int CLK_FREQ         = 50_000_000,
    parameter int DEBOUNCE_TIME_MS = 20,
    parameter int BTN_ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o
);

    localparam int   DB_CYC       = ms_to_cycles(CLK_FREQ, DEBOUNCE_TIME_MS);
    localparam int   CNT_W        = $clog2(DB_CYC + 1);
    // Raw level of a button at rest; the synchroniser resets to it so a
    // released button never looks pressed right after reset.
    localparam logic RELEASED_RAW = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [1:0]       sync_q;
    logic             pressed;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-stage synchroniser for the asynchronous pushbutton.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RELEASED_RAW}};
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign pressed = sync_q[1] ^ RELEASED_RAW;

    // Adopt the synced level only after DB_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (pressed == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DB_CYC - 1)) begin
            stable_q <= pressed;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/led_button_array.sv
// N_CH debounced buttons, each classified as short/long press and driving
// one LED in OFF/ON/BLINK mode. All blinking LEDs share one timebase.
module led_button_array
    import led_button_pkg::*;
#(
    parameter int N_CH             = 4,
    parameter int CLK_FREQ         = 50_000_000,
    parameter int DEBOUNCE_TIME_MS = 20,
    parameter int LONG_PRESS_MS    = 1000,
    parameter int BLINK_HALF_MS    = 250,
    parameter int BTN_ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   btn_i,
    output logic [N_CH-1:0]   led_o,
    output logic [N_CH-1:0]   short_pulse_o,
    output logic [N_CH-1:0]   long_pulse_o,
    output logic [2*N_CH-1:0] mode_o
);

    localparam int DB_CYC    = ms_to_cycles(CLK_FREQ, DEBOUNCE_TIME_MS);
    localparam int LONG_CYC  = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
    localparam int BLINK_CYC = ms_to_cycles(CLK_FREQ, BLINK_HALF_MS);
    localparam int HOLD_W    = $clog2(LONG_CYC + 1);
    localparam int BLINK_W   = $clog2(BLINK_CYC + 1);

    if (DB_CYC < 2 || LONG_CYC < 2 || BLINK_CYC < 2) begin : g_bad_timing
        $error("led_button_array: derived cycle counts must all be >= 2");
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("led_button_array: N_CH must be in 1..16");
    end

    logic [N_CH-1:0]    db_level;
    press_state_t       state_q [N_CH];
    press_state_t       state_d [N_CH];
    logic [HOLD_W-1:0]  hold_q  [N_CH];
    logic [HOLD_W-1:0]  hold_d  [N_CH];
    mode_t              mode_q  [N_CH];
    mode_t              mode_d  [N_CH];
    logic [N_CH-1:0]    short_d;
    logic [N_CH-1:0]    long_d;
    logic [N_CH-1:0]    led_d;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce #(
            .CLK_FREQ        (CLK_FREQ),
            .DEBOUNCE_TIME_MS(DEBOUNCE_TIME_MS),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (btn_i[i]),
            .level_o(db_level[i])
        );

        assign mode_o[2*i +: 2] = mode_q[i];
    end

    // Press classifier next state: short on release before the long
    // threshold, long exactly once when the hold reaches it.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            short_d[i] = 1'b0;
            long_d[i]  = 1'b0;
            case (state_q[i])
                P_IDLE: begin
                    if (db_level[i]) begin
                        state_d[i] = P_PRESSED;
                        hold_d[i]  = '0;
                    end
                end
                P_PRESSED: begin
                    if (!db_level[i]) begin
                        short_d[i] = 1'b1;
                        state_d[i] = P_IDLE;
                    end else if (hold_q[i] == HOLD_W'(LONG_CYC - 1)) begin
                        long_d[i]  = 1'b1;
                        state_d[i] = P_LONG_HELD;
                    end else begin
                        hold_d[i] = hold_q[i] + HOLD_W'(1);
                    end
                end
                P_LONG_HELD: begin
                    if (!db_level[i]) begin
                        state_d[i] = P_IDLE;
                    end
                end
                default: begin
                    state_d[i] = P_IDLE;
                end
            endcase
        end
    end

    // Mode next state, driven by the same events that become the pulses so
    // the new mode and the pulse appear together.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            mode_d[i] = mode_q[i];
            case (mode_q[i])
                MODE_OFF:   if (short_d[i]) mode_d[i] = MODE_ON;
                MODE_ON:    if (short_d[i]) mode_d[i] = MODE_OFF;
                MODE_BLINK: if (short_d[i]) mode_d[i] = MODE_OFF;
                default:    mode_d[i] = MODE_OFF;
            endcase
            if (long_d[i]) begin
                mode_d[i] = MODE_BLINK;
            end
        end
    end

    // LED level from the current mode and the shared blink phase.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (mode_q[i])
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = blink_phase_q;
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    // Per-channel state, mode, pulse and LED registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= P_IDLE;
                hold_q[i]  <= '0;
                mode_q[i]  <= MODE_OFF;
            end
            short_pulse_o <= '0;
            long_pulse_o  <= '0;
            led_o         <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
                mode_q[i]  <= mode_d[i];
            end
            short_pulse_o <= short_d;
            long_pulse_o  <= long_d;
            led_o         <= led_d;
        end
    end

    // Free-running blink timebase; never restarted so all LEDs stay in phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_CYC - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_led_button_array.sv
// Bench for led_button_array: directed scenarios plus randomized button
// activity, compared every cycle against an event-level reference model.
module tb_led_button_array;

    localparam int N_CH      = 4;
    localparam int DB_CYC    = 4;   // 1000 Hz * 4 ms
    localparam int LONG_CYC  = 20;  // 1000 Hz * 20 ms
    localparam int BLINK_CYC = 5;   // 1000 Hz * 5 ms

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N_CH-1:0]   btn = 4'hF;
    logic [N_CH-1:0]   led_o;
    logic [N_CH-1:0]   short_pulse_o;
    logic [N_CH-1:0]   long_pulse_o;
    logic [2*N_CH-1:0] mode_o;

    int checks = 0;
    int failures = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    led_button_array #(
        .N_CH            (N_CH),
        .CLK_FREQ        (1000),
        .DEBOUNCE_TIME_MS(4),
        .LONG_PRESS_MS   (20),
        .BLINK_HALF_MS   (5),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_i        (btn),
        .led_o        (led_o),
        .short_pulse_o(short_pulse_o),
        .long_pulse_o (long_pulse_o),
        .mode_o       (mode_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on whole events: raw samples reach the debouncer two edges late,
    // the debounced level flips once the last DB_CYC samples all disagree
    // with it, a long press is the edge LONG_CYC+1 after the debounced rise,
    // a short press is the edge after a debounced fall with no long press,
    // and the blink phase is a pure function of edges since reset.
    int              edge_n;
    logic [N_CH-1:0] rq1, rq2;
    logic [N_CH-1:0] m_db, m_db_last;
    int              rise_e [N_CH];
    bit              long_seen [N_CH];
    logic            win [N_CH][DB_CYC];
    logic [1:0]      m_mode [N_CH];
    logic [N_CH-1:0] exp_short = '0, exp_long = '0, exp_led = '0;
    logic [2*N_CH-1:0] exp_mode = '0;

    task automatic model_reset();
        edge_n = 0;
        rq1 = '1;
        rq2 = '1;
        m_db = '0;
        m_db_last = '0;
        exp_short = '0;
        exp_long = '0;
        exp_led = '0;
        exp_mode = '0;
        for (int c = 0; c < N_CH; c++) begin
            rise_e[c] = -1000;
            long_seen[c] = 1'b0;
            m_mode[c] = 2'd0;
            for (int k = 0; k < DB_CYC; k++) win[c][k] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic ph, d, in_v, all_diff;
            edge_n++;
            ph = (((edge_n - 1) / BLINK_CYC) % 2) == 1;
            for (int c = 0; c < N_CH; c++) begin
                d = m_db[c];
                exp_led[c] = (m_mode[c] == 2'd1) ? 1'b1 : (m_mode[c] == 2'd2) ? ph : 1'b0;
                exp_long[c] = d && (edge_n == rise_e[c] + 1 + LONG_CYC);
                exp_short[c] = !d && m_db_last[c] && !long_seen[c];
                if (exp_long[c]) begin
                    long_seen[c] = 1'b1;
                    m_mode[c] = 2'd2;
                end else if (exp_short[c]) begin
                    m_mode[c] = (m_mode[c] == 2'd0) ? 2'd1 : 2'd0;
                end
                exp_mode[2*c +: 2] = m_mode[c];
                m_db_last[c] = d;
                in_v = ~rq2[c];
                for (int k = 0; k < DB_CYC - 1; k++) win[c][k] = win[c][k+1];
                win[c][DB_CYC-1] = in_v;
                all_diff = 1'b1;
                for (int k = 0; k < DB_CYC; k++) if (win[c][k] == d) all_diff = 1'b0;
                if (all_diff) begin
                    m_db[c] = in_v;
                    if (in_v) begin
                        rise_e[c] = edge_n;
                        long_seen[c] = 1'b0;
                    end
                end
            end
            rq2 = rq1;
            rq1 = btn;
        end
    end

    // ---------------- compare process ----------------
    int short_cnt [N_CH];
    int long_cnt [N_CH];
    int both_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_led", 32'(led_o), 32'h0);
            check("reset_short", 32'(short_pulse_o), 32'h0);
            check("reset_long", 32'(long_pulse_o), 32'h0);
            check("reset_mode", 32'(mode_o), 32'h0);
        end else begin
            check("led_o", 32'(led_o), 32'(exp_led));
            check("short_pulse_o", 32'(short_pulse_o), 32'(exp_short));
            check("long_pulse_o", 32'(long_pulse_o), 32'(exp_long));
            check("mode_o", 32'(mode_o), 32'(exp_mode));
            for (int c = 0; c < N_CH; c++) begin
                short_cnt[c] += int'(short_pulse_o[c]);
                long_cnt[c] += int'(long_pulse_o[c]);
            end
            if (short_pulse_o[2] && long_pulse_o[3]) both_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int ch, input int cycles);
        btn[ch] = 1'b0;
        tick(cycles);
        btn[ch] = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap, lat, rem [N_CH];
        logic prev;
        for (int c = 0; c < N_CH; c++) begin
            short_cnt[c] = 0;
            long_cnt[c] = 0;
        end
        #1 rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(100);
        check("reset_quiet_pulses", 32'(short_cnt[0] + short_cnt[1] + long_cnt[0] + long_cnt[1]), 32'd0);
        check("reset_quiet_led", 32'(led_o), 32'h0);

        // bounce rejection, then one clean short press on ch0
        repeat (5) begin
            btn[0] = 1'b0;
            tick(3);
            btn[0] = 1'b1;
            tick(2);
        end
        tick(10);
        check("bounce_no_pulse", 32'(short_cnt[0] + long_cnt[0]), 32'd0);
        press(0, 10);
        tick(20);
        check("ch0_short_count", 32'(short_cnt[0]), 32'd1);
        check("ch0_mode_on", 32'(mode_o[1:0]), 32'd1);
        check("ch0_led_on", 32'(led_o[0]), 32'd1);

        press(0, 10);
        tick(20);
        check("ch0_short_count2", 32'(short_cnt[0]), 32'd2);
        check("ch0_mode_off", 32'(mode_o[1:0]), 32'd0);
        check("ch0_led_off", 32'(led_o[0]), 32'd0);

        // long press on ch1
        press(1, 40);
        tick(20);
        check("ch1_long_count", 32'(long_cnt[1]), 32'd1);
        check("ch1_no_short", 32'(short_cnt[1]), 32'd0);
        check("ch1_mode_blink", 32'(mode_o[3:2]), 32'd2);
        @(negedge clk);
        prev = led_o[1];
        gap = 0;
        while (led_o[1] == prev && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        prev = led_o[1];
        gap = 0;
        while (gap < 20) begin
            @(negedge clk);
            gap++;
            if (led_o[1] != prev) break;
        end
        check("ch1_blink_half_period", 32'(gap), 32'd5);
        @(posedge clk);
        #2;
        press(1, 10);
        tick(20);
        check("ch1_short_after_long", 32'(short_cnt[1]), 32'd1);
        check("ch1_mode_off", 32'(mode_o[3:2]), 32'd0);
        check("ch1_led_off", 32'(led_o[1]), 32'd0);

        // ch2 short release lands on the same edge as ch3 long threshold
        btn[3] = 1'b0;
        tick(5);
        press(2, 15);
        tick(20);
        btn[3] = 1'b1;
        tick(20);
        check("simul_both_seen", 32'(both_seen), 32'd1);
        check("simul_ch2_short", 32'(short_cnt[2]), 32'd1);
        check("simul_ch3_long", 32'(long_cnt[3]), 32'd1);
        check("simul_modes", 32'(mode_o), 32'h90);
        check("simul_ch2_led", 32'(led_o[2]), 32'd1);

        // reset during a hold; hold time before reset is not credited
        btn[0] = 1'b0;
        tick(21);
        check("midhold_no_long_yet", 32'(long_cnt[0]), 32'd0);
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (long_pulse_o[0]) begin
                lat = n;
                break;
            end
        end
        check("reset_hold_long_latency", 32'(lat), 32'd27);
        @(posedge clk);
        #2;
        btn[0] = 1'b1;
        tick(20);
        check("reset_hold_no_short", 32'(short_cnt[0]), 32'd2);

        // randomized activity on all channels, with one reset in the middle
        for (int c = 0; c < N_CH; c++) rem[c] = $urandom_range(1, 30);
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) rst_n = 1'b0;
            if (k == 704) rst_n = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (rem[c] == 0) begin
                    btn[c] = ~btn[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 45);
                end else begin
                    rem[c]--;
                end
            end
            tick(1);
        end
        btn = 4'hF;
        tick(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
